// File: rtl/binary_attn_score.sv
// binary_attn_score: buffers one binary Q/K/V sequence, then streams every XNOR-popcount
// score Q_i.K_j with V_j over ready/valid, pulsing done after the final beat.
module binary_attn_score #(
  parameter int SEQ_LEN = 30,
  parameter int DIM = 16,
  parameter int IDX_W = 5,
  parameter int SCORE_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIM-1:0]     q_in,
  input  logic [DIM-1:0]     k_in,
  input  logic [DIM-1:0]     v_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SCORE_W-1:0] score_out,
  output logic [IDX_W-1:0]   score_q_idx,
  output logic [IDX_W-1:0]   score_k_idx,
  output logic [DIM-1:0]     v_out,
  output logic               score_valid,
  input  logic               score_ready,
  output logic               score_last,
  output logic               done
);
  localparam int POP_W = $clog2(DIM + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);
  typedef enum logic {LOAD, COMPUTE} state_t;
  state_t state, state_nxt;
  logic [DIM-1:0] q_mem [SEQ_LEN];
  logic [DIM-1:0] k_mem [SEQ_LEN];
  logic [DIM-1:0] v_mem [SEQ_LEN];
  logic [IDX_W-1:0] wr_ptr, i_ptr, j_ptr;
  logic pend, accept, load_end, issue, fin;
  logic [DIM-1:0] xnor_bits;
  logic [POP_W-1:0] pop;
  logic [SCORE_W-1:0] score;
  assign in_ready = (state == LOAD) && !rst;
  assign accept = in_valid && in_ready;
  assign load_end = accept && wr_ptr == LAST;
  // pend marks that (i_ptr, j_ptr) still has to be pushed into the output register
  assign issue = pend && (!score_valid || score_ready);
  assign fin = score_valid && score_ready && score_last && score_q_idx == LAST;
  always_comb begin
    xnor_bits = ~(q_mem[i_ptr] ^ k_mem[j_ptr]);
    pop = '0;
    for (int b = 0; b < DIM; b++) pop = pop + POP_W'(xnor_bits[b]);
    score = SCORE_W'({pop, 1'b0}) - SCORE_W'(DIM);
  end
  always_comb begin
    state_nxt = state;
    if (state == LOAD) state_nxt = load_end ? COMPUTE : LOAD;
    else state_nxt = fin ? LOAD : COMPUTE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (accept) begin
      q_mem[wr_ptr] <= q_in;
      k_mem[wr_ptr] <= k_in;
      v_mem[wr_ptr] <= v_in;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      i_ptr <= '0;
      j_ptr <= '0;
      pend <= 1'b0;
      score_out <= '0;
      score_q_idx <= '0;
      score_k_idx <= '0;
      v_out <= '0;
      score_valid <= 1'b0;
      score_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (accept) wr_ptr <= load_end ? '0 : wr_ptr + 1'b1;
      if (load_end) begin
        pend <= 1'b1;
        i_ptr <= '0;
        j_ptr <= '0;
      end else if (issue) begin
        score_out <= score;
        score_q_idx <= i_ptr;
        score_k_idx <= j_ptr;
        v_out <= v_mem[j_ptr];
        score_last <= j_ptr == LAST;
        score_valid <= 1'b1;
        pend <= !(i_ptr == LAST && j_ptr == LAST);
        j_ptr <= j_ptr == LAST ? '0 : j_ptr + 1'b1;
        i_ptr <= j_ptr != LAST ? i_ptr : i_ptr == LAST ? '0 : i_ptr + 1'b1;
      end else if (score_ready) score_valid <= 1'b0;
    end
endmodule
